// File: rtl/bounce_pkg.sv
// Shared definitions for the switch-bounce emulator: FSM states and LFSR constants.
package bounce_pkg;

  localparam int LFSR_W = 16;
  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_BOUNCE = 1'b1
  } bounce_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR; restarts from SEED on reset so bounce patterns are repeatable.
module lfsr16
  import bounce_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/bounce_gen.sv
// Mechanical contact bounce emulator: follows a clean level i, and when enabled chatters o with
// pseudo-random segment lengths for a fixed window after each edge before settling on the target.
module bounce_gen
  import bounce_pkg::*;
#(
  parameter int                BOUNCE_CYCLES = 64,
  parameter int                SEG_W         = 3,
  parameter logic [LFSR_W-1:0] SEED          = DEFAULT_SEED
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i,
  input  logic en,
  output logic o,
  output logic busy_o,
  output logic done_o
);

  localparam int WIN_W = $clog2(BOUNCE_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(BOUNCE_CYCLES - 1);

  bounce_state_e     state_q, state_d;
  logic              tgt_q, tgt_d;
  logic              o_q, o_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [LFSR_W-1:0] lfsr;
  logic              edge_det;
  logic              lfsr_unused;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .state_o(lfsr)
  );

  assign edge_det    = (i != tgt_q);
  assign lfsr_unused = ^lfsr[LFSR_W-1:SEG_W];

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    o_d     = o_q;
    win_d   = win_q;
    seg_d   = seg_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_d = tgt_q;
        if (edge_det) begin
          tgt_d = i;
          o_d   = i;
          if (en) begin
            state_d = ST_BOUNCE;
            win_d   = WIN_LOAD;
            seg_d   = lfsr[SEG_W-1:0];
          end
        end
      end
      ST_BOUNCE: begin
        // A retrigger on the final cycle wins over ending the window.
        if (!edge_det && win_q == '0) begin
          o_d     = tgt_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (edge_det) begin
            tgt_d = i;
            win_d = WIN_LOAD;
          end else begin
            win_d = win_q - 1'b1;
          end
          if (seg_q == '0) begin
            o_d   = ~o_q;
            seg_d = lfsr[SEG_W-1:0];
          end else begin
            seg_d = seg_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_BOUNCE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= 1'b0;
      o_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      win_q   <= '0;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      win_q   <= win_d;
      seg_q   <= seg_d;
    end
  end

  assign o      = o_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Self-checking bench for bounce_gen: a schedule-based reference model (window end time and
// next-toggle time computed from the LFSR sequence) is compared against the DUT every cycle.
module tb_bounce_gen;

  localparam int          BC    = 64;
  localparam int          SEG_W = 3;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          MIN_TOGGLES = (BC - 1) / (1 << SEG_W);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic i     = 1'b0;
  logic en    = 1'b0;
  logic o, busy_o, done_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bounce_gen #(
    .BOUNCE_CYCLES(BC),
    .SEG_W        (SEG_W),
    .SEED         (SEED)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i),
    .en    (en),
    .o     (o),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  // Reference model state: when the window ends and when the next chatter toggle is due.
  logic [15:0] m_lfsr;
  logic        m_tgt, m_o, m_busy, m_done;
  int          m_k, m_end, m_next;

  function automatic logic [15:0] galois(input logic [15:0] s);
    logic [15:0] sh;
    sh = s >> 1;
    return s[0] ? (sh ^ 16'hB400) : sh;
  endfunction

  task automatic model_reset();
    m_lfsr = SEED;
    m_tgt  = 1'b0;
    m_o    = 1'b0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_k    = 0;
    m_end  = 0;
    m_next = 0;
  endtask

  task automatic model_edge(input logic ii, input logic ee);
    int seg_len;
    seg_len = int'(m_lfsr % 16'(1 << SEG_W)) + 1;
    m_k++;
    m_done = 1'b0;
    if (m_busy) begin
      if (ii != m_tgt) begin
        m_tgt = ii;
        m_end = m_k + BC;
      end
      if (m_k == m_end) begin
        m_o    = m_tgt;
        m_busy = 1'b0;
        m_done = 1'b1;
      end else if (m_k == m_next) begin
        m_o    = ~m_o;
        m_next = m_k + seg_len;
      end
    end else if (ii != m_tgt) begin
      m_tgt = ii;
      m_o   = ii;
      if (ee) begin
        m_busy = 1'b1;
        m_end  = m_k + BC;
        m_next = m_k + seg_len;
      end
    end
    m_lfsr = galois(m_lfsr);
  endtask

  task automatic tick(input logic ii, input logic ee);
    i  = ii;
    en = ee;
    @(posedge clk);
    if (rst_n) model_edge(ii, ee);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i  = 1'b1;
    en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({o, busy_o, done_o} !== 3'b000)
      begin errors++; $display("FAIL reset_async got o/busy/done=%b%b%b want 000", o, busy_o, done_o); end
    for (int c = 0; c < 3; c++) begin
      tick(1'b1, 1'b0);
      checks++;
      if ({o, busy_o, done_o} !== 3'b000)
        begin errors++; $display("FAIL reset_hold c=%0d got o/busy/done=%b%b%b want 000", c, o, busy_o, done_o); end
    end
    rst_n = 1'b1;
    tick(1'b1, 1'b0);
    checks++;
    if (o !== 1'b1) begin errors++; $display("FAIL reset_first_edge got o=%b want 1", o); end
    for (int c = 0; c < 4; c++) begin
      tick(1'b1, 1'b0);
      checks++;
      if ({o, busy_o, done_o} !== {m_o, m_busy, m_done})
        begin errors++; $display("FAIL reset_after k=%0d got %b%b%b want %b%b%b", m_k, o, busy_o, done_o, m_o, m_busy, m_done); end
    end
  endtask

  task automatic test_no_bounce();
    int   toggles;
    logic prev, lvl;
    do_reset();
    toggles = 0;
    prev = o;
    lvl  = 1'b0;
    for (int n = 0; n < 8; n++) begin
      lvl = ~lvl;
      tick(lvl, 1'b0);
      checks++;
      if ({o, busy_o, done_o} !== {lvl, 2'b00})
        begin errors++; $display("FAIL no_bounce_edge n=%0d got %b%b%b want %b00", n, o, busy_o, done_o, lvl); end
      if (o !== prev) toggles++;
      prev = o;
      for (int h = 0; h < int'($urandom_range(1, 5)); h++) begin
        tick(lvl, 1'b0);
        checks++;
        if ({o, busy_o, done_o} !== {m_o, m_busy, m_done})
          begin errors++; $display("FAIL no_bounce_hold k=%0d got %b%b%b want %b%b%b", m_k, o, busy_o, done_o, m_o, m_busy, m_done); end
        if (o !== prev) toggles++;
        prev = o;
      end
    end
    checks++;
    if (toggles != 8) begin errors++; $display("FAIL no_bounce_toggles got %0d want 8", toggles); end
  endtask

  task automatic test_bounce_window();
    int   busy_cnt, done_at, toggles;
    logic prev, lvl;
    do_reset();
    lvl = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int g = 0; g < int'($urandom_range(1, 20)); g++) tick(lvl, 1'b1);
      lvl = ~lvl;
      tick(lvl, 1'b1);
      checks++;
      if ({o, busy_o} !== {lvl, 1'b1})
        begin errors++; $display("FAIL window_start r=%0d got o/busy=%b%b want %b1", r, o, busy_o, lvl); end
      busy_cnt = 1;
      done_at  = -1;
      toggles  = 0;
      prev     = o;
      for (int c = 1; c <= BC + 6; c++) begin
        // en is only sampled at window start, so wiggle it freely here
        tick(lvl, 1'($urandom_range(0, 1)));
        checks++;
        if ({o, busy_o, done_o} !== {m_o, m_busy, m_done})
          begin errors++; $display("FAIL window_cycle r=%0d c=%0d got %b%b%b want %b%b%b", r, c, o, busy_o, done_o, m_o, m_busy, m_done); end
        if (busy_o === 1'b1) busy_cnt++;
        if (done_o === 1'b1) done_at = c;
        if (c < BC && o !== prev) toggles++;
        prev = o;
      end
      checks++;
      if (busy_cnt != BC) begin errors++; $display("FAIL window_busy_len r=%0d got %0d want %0d", r, busy_cnt, BC); end
      checks++;
      if (done_at != BC) begin errors++; $display("FAIL window_done_at r=%0d got %0d want %0d", r, done_at, BC); end
      checks++;
      if (toggles < MIN_TOGGLES) begin errors++; $display("FAIL window_toggles r=%0d got %0d want >=%0d", r, toggles, MIN_TOGGLES); end
      checks++;
      if (o !== lvl) begin errors++; $display("FAIL window_settle r=%0d got o=%b want %b", r, o, lvl); end
    end
  endtask

  task automatic test_retrigger();
    int busy_cnt, done_at, done_cnt;
    do_reset();
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    busy_cnt = 1;
    done_at  = -1;
    done_cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      tick((c >= 20) ? 1'b0 : 1'b1, 1'b1);
      checks++;
      if ({o, busy_o, done_o} !== {m_o, m_busy, m_done})
        begin errors++; $display("FAIL retrig_cycle c=%0d got %b%b%b want %b%b%b", c, o, busy_o, done_o, m_o, m_busy, m_done); end
      if (busy_o === 1'b1) busy_cnt++;
      if (done_o === 1'b1) begin done_at = c; done_cnt++; end
    end
    checks++;
    if (busy_cnt != 20 + BC) begin errors++; $display("FAIL retrig_busy_len got %0d want %0d", busy_cnt, 20 + BC); end
    checks++;
    if (done_cnt != 1 || done_at != 20 + BC)
      begin errors++; $display("FAIL retrig_done got count=%0d at=%0d want count=1 at=%0d", done_cnt, done_at, 20 + BC); end
    checks++;
    if (o !== 1'b0) begin errors++; $display("FAIL retrig_final got o=%b want 0", o); end
  endtask

  task automatic test_reset_midwindow();
    logic [29:0] tr0, tr1, tr;
    tr0 = '0;
    tr1 = '0;
    for (int p = 0; p < 2; p++) begin
      tr = '0;
      do_reset();
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      for (int c = 0; c < 30; c++) begin
        tick(1'b1, 1'b1);
        tr[c] = o;
        checks++;
        if ({o, busy_o, done_o} !== {m_o, m_busy, m_done})
          begin errors++; $display("FAIL midrst_cycle p=%0d c=%0d got %b%b%b want %b%b%b", p, c, o, busy_o, done_o, m_o, m_busy, m_done); end
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({o, busy_o, done_o} !== 3'b000)
        begin errors++; $display("FAIL midrst_abort p=%0d got o/busy/done=%b%b%b want 000", p, o, busy_o, done_o); end
      for (int c = 0; c < 2; c++) begin
        tick(1'b1, 1'b1);
        checks++;
        if ({o, busy_o, done_o} !== 3'b000)
          begin errors++; $display("FAIL midrst_hold p=%0d got o/busy/done=%b%b%b want 000", p, o, busy_o, done_o); end
      end
      if (p == 0) tr0 = tr; else tr1 = tr;
    end
    checks++;
    if (tr1 !== tr0) begin errors++; $display("FAIL midrst_repeat got trace=%h want %h", tr1, tr0); end
  endtask

  task automatic test_random();
    logic lvl;
    do_reset();
    lvl = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 39) == 0) lvl = ~lvl;
      tick(lvl, 1'($urandom_range(0, 1)));
      checks++;
      if ({o, busy_o, done_o} !== {m_o, m_busy, m_done})
        begin errors++; $display("FAIL random_cycle k=%0d got %b%b%b want %b%b%b", m_k, o, busy_o, done_o, m_o, m_busy, m_done); end
    end
  endtask

  task automatic test_debounce();
    logic db_state;
    int   db_cnt, ups, downs;
    logic lvl;
    do_reset();
    db_state = 1'b0;
    db_cnt = 0;
    ups = 0;
    downs = 0;
    for (int n = 0; n < 20; n++) begin
      lvl = (n % 2 == 0);
      for (int c = 0; c < 250; c++) begin
        tick(lvl, 1'b1);
        checks++;
        if ({o, busy_o, done_o} !== {m_o, m_busy, m_done})
          begin errors++; $display("FAIL debounce_cycle n=%0d c=%0d got %b%b%b want %b%b%b", n, c, o, busy_o, done_o, m_o, m_busy, m_done); end
        // Debouncer: accept a new level only after 16 stable cycles (longer than any segment).
        if (o === db_state) db_cnt = 0;
        else db_cnt++;
        if (db_cnt == 16) begin
          db_state = ~db_state;
          db_cnt = 0;
          if (db_state) ups++; else downs++;
        end
      end
    end
    checks++;
    if (ups != 10 || downs != 10)
      begin errors++; $display("FAIL debounce_pulses got up=%0d down=%0d want up=10 down=10", ups, downs); end
  endtask

  initial begin
    #2;
    test_reset();
    test_no_bounce();
    test_bounce_window();
    test_retrigger();
    test_reset_midwindow();
    test_random();
    test_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
